// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the ARMAria phase sequencer: phase encodings,
// special instruction IDs and the memory wait-state limits.
package phase_sequencer_pkg;

  typedef enum logic [3:0] {
    PH_IDLE       = 4'd0,
    PH_FETCH      = 4'd1,
    PH_FETCH_WAIT = 4'd2,
    PH_DECODE     = 4'd3,
    PH_EXECUTE    = 4'd4,
    PH_MEMORY     = 4'd5,
    PH_MEM_WAIT   = 4'd6,
    PH_WRITEBACK  = 4'd7,
    PH_INPUT_WAIT = 4'd8,
    PH_HALT       = 4'd9
  } phase_t;

  localparam logic [6:0] ID_INSW      = 7'd71;
  localparam logic [6:0] ID_RESET     = 7'd100;
  localparam int         MEM_WAIT_MAX = 7;
  localparam int         WAIT_W       = 3;

  // Value loaded into the down-counter so that the wait phase lasts wait_cycles cycles.
  function automatic logic [WAIT_W-1:0] wait_load_value(input int wait_cycles);
    logic [WAIT_W-1:0] value;
    if (wait_cycles <= 0) begin
      value = '0;
    end else if (wait_cycles > MEM_WAIT_MAX) begin
      value = WAIT_W'(MEM_WAIT_MAX - 1);
    end else begin
      value = WAIT_W'(wait_cycles - 1);
    end
    return value;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Memory wait-state down-counter shared by the fetch and data-access waits.
// Loaded on the access cycle; done is high in the last wait cycle.
module wait_counter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);
  import phase_sequencer_pkg::*;

  localparam logic [WAIT_W-1:0] LOAD_VALUE = wait_load_value(WAIT_CYCLES);

  logic [WAIT_W-1:0] count_r;

  // Down-counter: load on the access cycle, count to zero, then rest.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= LOAD_VALUE;
    end else if (count_r != '0) begin
      count_r <= count_r - 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle phase controller: fetch/decode/execute/memory/writeback strobes,
// halt, retire counter. Optional INPUT_CONFIRM_EN builds the INSW confirm wait.
module phase_sequencer #(
  parameter int MEM_WAIT     = 1,
  parameter int RETIRE_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [6:0]              instr_id,
  input  logic                    core_enable,
  input  logic [2:0]              ctrl_rb,
  input  logic [2:0]              ctrl_mah,
  input  logic                    mem_we_req,
  input  logic [2:0]              specreg_mode,
  input  logic                    input_confirm,
  output logic [3:0]              phase,
  output logic                    ir_load,
  output logic                    pc_enable,
  output logic                    rb_write_enable,
  output logic                    specreg_write,
  output logic                    mem_write_strobe,
  output logic                    input_wait,
  output logic                    halted,
  output logic [RETIRE_WIDTH-1:0] retired
);
  import phase_sequencer_pkg::*;

  localparam bit NO_WAIT = (MEM_WAIT == 0);

  phase_t                  state_r;
  phase_t                  state_next_s;
  logic                    rb_req_r;
  logic                    mem_req_r;
  logic                    we_req_r;
  logic                    sr_req_r;
  logic [RETIRE_WIDTH-1:0] retired_r;
  logic                    wait_load_s;
  logic                    wait_done_s;

`ifdef INPUT_CONFIRM_EN
  logic confirm_q_r;
  logic confirm_edge_s;

  // Previous confirm level, so a level already high on entry is not taken as an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      confirm_q_r <= 1'b0;
    end else begin
      confirm_q_r <= input_confirm;
    end
  end

  assign confirm_edge_s = input_confirm & ~confirm_q_r;
`else
  logic unused_inputs_s;
  assign unused_inputs_s = ^{instr_id, input_confirm};
`endif

  wait_counter #(
    .WAIT_CYCLES(MEM_WAIT)
  ) u_wait_counter (
    .clock(clock),
    .reset(reset),
    .load (wait_load_s),
    .done (wait_done_s)
  );

  // Phase register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= PH_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request flags are captured from the control core only in DECODE.
  always_ff @(posedge clock) begin
    if (reset) begin
      rb_req_r  <= 1'b0;
      mem_req_r <= 1'b0;
      we_req_r  <= 1'b0;
      sr_req_r  <= 1'b0;
    end else if (state_r == PH_DECODE) begin
      rb_req_r  <= (ctrl_rb != 3'd0);
      mem_req_r <= (ctrl_mah != 3'd0);
      we_req_r  <= mem_we_req;
      sr_req_r  <= (specreg_mode != 3'd0);
    end else begin
      rb_req_r  <= rb_req_r;
      mem_req_r <= mem_req_r;
      we_req_r  <= we_req_r;
      sr_req_r  <= sr_req_r;
    end
  end

  // Retired-instruction counter, wrapping naturally at its width.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_r <= '0;
    end else if (state_r == PH_WRITEBACK) begin
      retired_r <= retired_r + 1'b1;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Next-phase logic and wait-counter load.
  always_comb begin
    state_next_s = state_r;
    wait_load_s  = 1'b0;
    case (state_r)
      PH_IDLE: state_next_s = PH_FETCH;
      PH_FETCH: begin
        wait_load_s = 1'b1;
        if (NO_WAIT) state_next_s = PH_DECODE;
        else         state_next_s = PH_FETCH_WAIT;
      end
      PH_FETCH_WAIT: begin
        if (wait_done_s) state_next_s = PH_DECODE;
        else             state_next_s = PH_FETCH_WAIT;
      end
      PH_DECODE: begin
        // A halt request overrides every other decode outcome.
        if (!core_enable) begin
          state_next_s = PH_HALT;
`ifdef INPUT_CONFIRM_EN
        end else if (instr_id == ID_INSW) begin
          state_next_s = PH_INPUT_WAIT;
`endif
        end else begin
          state_next_s = PH_EXECUTE;
        end
      end
      PH_EXECUTE: begin
        if (mem_req_r) state_next_s = PH_MEMORY;
        else           state_next_s = PH_WRITEBACK;
      end
      PH_MEMORY: begin
        wait_load_s = 1'b1;
        if (NO_WAIT) state_next_s = PH_WRITEBACK;
        else         state_next_s = PH_MEM_WAIT;
      end
      PH_MEM_WAIT: begin
        if (wait_done_s) state_next_s = PH_WRITEBACK;
        else             state_next_s = PH_MEM_WAIT;
      end
      PH_WRITEBACK: state_next_s = PH_FETCH;
`ifdef INPUT_CONFIRM_EN
      PH_INPUT_WAIT: begin
        if (confirm_edge_s) state_next_s = PH_EXECUTE;
        else                state_next_s = PH_INPUT_WAIT;
      end
`endif
      PH_HALT: state_next_s = PH_HALT;
      default: state_next_s = PH_IDLE;
    endcase
  end

  // Moore strobes decoded from the phase and the latched request flags.
  always_comb begin
    ir_load          = 1'b0;
    pc_enable        = 1'b0;
    rb_write_enable  = 1'b0;
    specreg_write    = 1'b0;
    mem_write_strobe = 1'b0;
    input_wait       = 1'b0;
    halted           = 1'b0;
    case (state_r)
      PH_FETCH:      ir_load = NO_WAIT;
      PH_FETCH_WAIT: ir_load = wait_done_s;
      PH_MEMORY:     mem_write_strobe = we_req_r;
      PH_WRITEBACK: begin
        rb_write_enable = rb_req_r;
        specreg_write   = sr_req_r;
        pc_enable       = 1'b1;
      end
`ifdef INPUT_CONFIRM_EN
      PH_INPUT_WAIT: input_wait = 1'b1;
`endif
      PH_HALT:       halted = 1'b1;
      default:       ir_load = 1'b0;
    endcase
  end

  assign phase   = state_r;
  assign retired = retired_r;

endmodule
